// File: rtl/simple_bus_mem_slave.sv
// Memory target on the simple_bus: grants the bus to one master and runs one
// read, write or swap per start strobe against a DEPTH x DATA_W RAM.
module simple_bus_mem_slave #(
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        mode,
  input  logic              start,
  input  logic [DATA_W-1:0] data_i,
  output logic              gnt,
  output logic              rdy,
  output logic [DATA_W-1:0] data_o,
  output logic              data_oe
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;
  localparam int unsigned CNT_W = 4;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_GRANTED = 2'd1;
  localparam logic [1:0] S_BUSY    = 2'd2;
  localparam logic [1:0] S_RESP    = 2'd3;

  localparam logic [1:0] M_READ  = 2'b00;
  localparam logic [1:0] M_WRITE = 2'b01;
  localparam logic [1:0] M_SWAP  = 2'b10;

  logic [1:0]        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rd_q, rd_d;
  logic              gnt_d, rdy_d, data_oe_d;
  logic [DATA_W-1:0] data_o_d;
  logic              avail_c;
  logic              mem_we_c;

  logic [DATA_W-1:0] mem [DEPTH];

  // State and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      mode_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      gnt     <= 1'b0;
      rdy     <= 1'b0;
      data_o  <= '0;
      data_oe <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      addr_q  <= addr_d;
      mode_q  <= mode_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      gnt     <= gnt_d;
      rdy     <= rdy_d;
      data_o  <= data_o_d;
      data_oe <= data_oe_d;
    end
  end

  // RAM has no reset; a write only lands on the BUSY exit edge
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Next state, transfer capture and output staging
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    addr_d    = addr_q;
    mode_d    = mode_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    mem_we_c  = 1'b0;
    data_o_d  = '0;
    data_oe_d = 1'b0;

    avail_c = (state == S_IDLE) || (state == S_GRANTED);
    gnt_d   = req & avail_c;
    rdy_d   = (state == S_RESP);

    case (state)
      S_IDLE: begin
        if (gnt) begin
          state_d = S_GRANTED;
        end
      end
      S_GRANTED: begin
        if (start && gnt) begin
          addr_d  = addr;
          mode_d  = mode;
          wdata_d = data_i;
          cnt_d   = CNT_W'(WAIT_STATES);
          state_d = S_BUSY;
        end else if (!req) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt != '0) begin
          cnt_d = cnt - CNT_W'(1);
        end else begin
          // Old word is captured on the same edge a swap overwrites it
          rd_d     = mem[addr_q];
          mem_we_c = (mode_q == M_WRITE) || (mode_q == M_SWAP);
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if ((mode_q == M_READ) || (mode_q == M_SWAP)) begin
          data_o_d  = rd_q;
          data_oe_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_simple_bus_mem_slave.sv
// Scoreboard bench: two slaves (0 and 3 wait states) share the stimulus; a
// behavioural memory model predicts each response, monitors check on rdy.
module tb_simple_bus_mem_slave;

  typedef struct {
    logic [7:0] data;
    logic       oe;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req;
  logic [7:0] addr;
  logic [1:0] mode;
  logic       start;
  logic [7:0] data_i;

  logic       gnt0, rdy0, oe0;
  logic [7:0] do0;
  logic       gnt3, rdy3, oe3;
  logic [7:0] do3;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q3[$];

  logic [7:0] mem_m [256];
  bit         wr_m  [256];

  simple_bus_mem_slave #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .mode(mode),
    .start(start), .data_i(data_i), .gnt(gnt0), .rdy(rdy0),
    .data_o(do0), .data_oe(oe0)
  );

  simple_bus_mem_slave #(.ADDR_W(8), .DATA_W(8), .WAIT_STATES(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .mode(mode),
    .start(start), .data_i(data_i), .gnt(gnt3), .rdy(rdy3),
    .data_o(do3), .data_oe(oe3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the zero-wait-state slave
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy0) begin
        if (q0.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ws0 unexpected rdy: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q0.pop_front();
          check("ws0 data_o", 32'(do0), 32'(e.data));
          check("ws0 data_oe", 32'(oe0), 32'(e.oe));
          check("ws0 rdy cycle", cyc, e.cyc);
        end
      end else begin
        check("ws0 idle data_oe", 32'(oe0), 32'd0);
        check("ws0 idle data_o", 32'(do0), 32'd0);
      end
    end
  end

  // Monitor for the three-wait-state slave
  always @(negedge clk) begin
    if (rst_n) begin
      if (rdy3) begin
        if (q3.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL ws3 unexpected rdy: got 1, expected 0 (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = q3.pop_front();
          check("ws3 data_o", 32'(do3), 32'(e.data));
          check("ws3 data_oe", 32'(oe3), 32'(e.oe));
          check("ws3 rdy cycle", cyc, e.cyc);
        end
      end else begin
        check("ws3 idle data_oe", 32'(oe3), 32'd0);
        check("ws3 idle data_o", 32'(do3), 32'd0);
      end
    end
  end

  // Request the bus, issue one start; commit=0 leaves model and queues untouched
  task automatic start_xfer(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d,
                            input bit commit, output int c);
    exp_t e;
    int   k;
    req = 1'b1;
    k = 0;
    @(negedge clk);
    while (!gnt0 && k < 10) begin
      @(negedge clk);
      k++;
    end
    if (!gnt0) check("grant wait timeout", 32'(gnt0), 32'd1);
    @(negedge clk);
    start  = 1'b1;
    mode   = m;
    addr   = a;
    data_i = d;
    c = cyc;
    if (commit) begin
      e.data = 8'h00;
      e.oe   = 1'b0;
      case (m)
        2'b00: begin e.data = mem_m[a]; e.oe = 1'b1; end
        2'b01: begin mem_m[a] = d; wr_m[a] = 1'b1; end
        2'b10: begin e.data = mem_m[a]; e.oe = 1'b1; mem_m[a] = d; wr_m[a] = 1'b1; end
        default: ;
      endcase
      e.cyc = c + 3;
      q0.push_back(e);
      e.cyc = c + 6;
      q3.push_back(e);
    end
    @(negedge clk);
    start  = 1'b0;
    req    = 1'b0;
    addr   = 8'($urandom);
    data_i = 8'($urandom);
    mode   = 2'($urandom);
  endtask

  task automatic do_xfer(input logic [1:0] m, input logic [7:0] a, input logic [7:0] d,
                         input bit extra_start);
    int c;
    start_xfer(m, a, d, 1'b1, c);
    // A second strobe while BUSY must be ignored
    if (extra_start) begin
      start  = 1'b1;
      mode   = 2'b01;
      addr   = a;
      data_i = ~d;
    end
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  initial begin
    int c;
    rst_n = 1'b0; req = 1'b0; start = 1'b0;
    addr = '0; mode = '0; data_i = '0;
    repeat (3) @(negedge clk);
    check("reset gnt", 32'(gnt0), 32'd0);
    check("reset rdy", 32'(rdy0), 32'd0);
    check("reset data_oe", 32'(oe0), 32'd0);
    check("reset data_o", 32'(do0), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Grant follows req with one edge of latency
    check("gnt before req", 32'(gnt0), 32'd0);
    req = 1'b1;
    @(negedge clk);
    check("gnt ws0 after req", 32'(gnt0), 32'd1);
    check("gnt ws3 after req", 32'(gnt3), 32'd1);
    req = 1'b0;
    @(negedge clk);
    check("gnt after req drop", 32'(gnt0), 32'd0);
    repeat (3) @(negedge clk);

    do_xfer(2'b01, 8'h10, 8'hA5, 1'b0);
    do_xfer(2'b00, 8'h10, 8'h00, 1'b1);
    do_xfer(2'b01, 8'hFF, 8'h3C, 1'b0);
    do_xfer(2'b10, 8'hFF, 8'h81, 1'b0);
    do_xfer(2'b00, 8'hFF, 8'h00, 1'b0);
    do_xfer(2'b01, 8'h00, 8'h5E, 1'b1);
    do_xfer(2'b00, 8'h00, 8'h00, 1'b0);

    // Start with no grant is ignored
    start = 1'b1; mode = 2'b01; addr = 8'h10; data_i = 8'h00;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    do_xfer(2'b11, 8'h10, 8'h77, 1'b0);
    do_xfer(2'b00, 8'h10, 8'h00, 1'b0);

    // Reset mid-transfer drops a pending write
    do_xfer(2'b01, 8'h20, 8'h5A, 1'b0);
    start_xfer(2'b01, 8'h20, 8'hEE, 1'b0, c);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    do_xfer(2'b00, 8'h20, 8'h00, 1'b0);

    // Asynchronous reset clears outputs while rdy/data_oe are high
    start_xfer(2'b00, 8'h10, 8'h00, 1'b1, c);
    repeat (2) @(posedge clk);
    #1;
    check("rdy before async reset", 32'(rdy0), 32'd1);
    check("data_oe before async reset", 32'(oe0), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async reset rdy", 32'(rdy0), 32'd0);
    check("async reset data_oe", 32'(oe0), 32'd0);
    check("async reset data_o", 32'(do0), 32'd0);
    check("async reset gnt", 32'(gnt0), 32'd0);
    q0.delete();
    q3.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Async reset while the grant is held
    req = 1'b1;
    repeat (2) @(negedge clk);
    check("gnt held", 32'(gnt3), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset gnt ws0", 32'(gnt0), 32'd0);
    check("async reset gnt ws3", 32'(gnt3), 32'd0);
    req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      logic [1:0] m;
      logic [7:0] a;
      m = 2'($urandom_range(0, 3));
      a = 8'($urandom);
      if (!wr_m[a] && (m == 2'b00 || m == 2'b10)) m = 2'b01;
      do_xfer(m, a, 8'($urandom), bit'($urandom_range(0, 1)));
    end

    repeat (10) @(negedge clk);
    check("ws0 outstanding responses", q0.size(), 32'd0);
    check("ws3 outstanding responses", q3.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
